// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED codec family: code geometry helpers,
// the parity-coverage rule, and the status encoding used by the decoder.
package hamming_pkg;

  localparam logic [1:0] ST_CLEAN  = 2'd0;
  localparam logic [1:0] ST_CORR   = 2'd1;
  localparam logic [1:0] ST_UNCORR = 2'd2;

  function automatic bit is_pow2(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  function automatic int code_width(input int data_w, input int par_w);
    return data_w + par_w + 1;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int data_index(input int pos);
    int idx;
    idx = 0;
    for (int p = 1; p < pos; p++) begin
      if (!is_pow2(p)) idx++;
    end
    return idx;
  endfunction

  // Parity bit k covers every position whose index has bit k set.
  function automatic bit covers(input int pos, input int k);
    return ((pos >> k) & 1) == 1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword
// (bit 0 = overall parity, bit i = Hamming position i).
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int N     = 8,
  parameter int PAR_W = 3
) (
  input  logic [N-1:0]     code,
  output logic [PAR_W-1:0] syn,
  output logic             par
);

  always_comb begin
    syn = '0;
    for (int k = 0; k < PAR_W; k++) begin
      for (int i = 1; i < N; i++) begin
        if (covers(i, k)) syn[k] = syn[k] ^ code[i];
      end
    end
    par = ^code;
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage valid/ready Hamming SECDED decoder with saturating health counters
// for corrected and uncorrectable beats.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+PAR_W:0]   code_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic                    err_corr,
  output logic                    err_uncorr,
  output logic [PAR_W-1:0]        err_pos,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        corr_cnt,
  output logic [CNT_W-1:0]        uncorr_cnt
);

  localparam int N = code_width(DATA_W, PAR_W);

  if (((1 << PAR_W) < N) || ((1 << (PAR_W - 1)) > N - 1)) begin : g_cfg_err
    $error("hamming_secded_dec: PAR_W does not fit DATA_W");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             vld_p1, vld_p2;
  logic             adv_p2;
  logic [N-1:0]     code_p1;
  logic [PAR_W-1:0] syn_p0, syn_p1;
  logic             par_p0, par_p1;

  assign adv_p2    = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || adv_p2;
  assign out_valid = vld_p2;

  hamming_syndrome #(.N(N), .PAR_W(PAR_W)) u_syndrome (
    .code (code_in),
    .syn  (syn_p0),
    .par  (par_p0)
  );

  // ---- stage 1: capture codeword, syndrome and overall parity ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      code_p1 <= code_in;
      syn_p1  <= syn_p0;
      par_p1  <= par_p0;
    end
  end

  logic [1:0]        status_p1;
  logic [N-1:0]      fixed_p1;
  logic [DATA_W-1:0] data_p1;
  logic              unused_chk_p1;

  always_comb begin
    status_p1 = ST_CLEAN;
    fixed_p1  = code_p1;
    if (par_p1) begin
      if (int'(syn_p1) <= N - 1) begin
        status_p1 = ST_CORR;
        fixed_p1  = code_p1 ^ (N'(1) << syn_p1);
      end else begin
        status_p1 = ST_UNCORR;
      end
    end else if (syn_p1 != '0) begin
      status_p1 = ST_UNCORR;
    end

    // Check bits were already consumed by the syndrome; only data is extracted.
    data_p1       = '0;
    unused_chk_p1 = fixed_p1[0];
    for (int pos = 1; pos < N; pos++) begin
      if (is_pow2(pos)) unused_chk_p1 = unused_chk_p1 ^ fixed_p1[pos];
      else              data_p1[data_index(pos)] = fixed_p1[pos];
    end
  end

  // ---- stage 2: registered result, held while downstream stalls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      err_pos    <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_out   <= data_p1;
        err_corr   <= (status_p1 == ST_CORR);
        err_uncorr <= (status_p1 == ST_UNCORR);
        err_pos    <= syn_p1;
      end
    end
  end

  logic             xfer;
  logic [CNT_W-1:0] corr_cnt_d, uncorr_cnt_d;

  assign xfer = vld_p2 && out_ready;

  always_comb begin
    corr_cnt_d   = corr_cnt;
    uncorr_cnt_d = uncorr_cnt;
    if (xfer && err_corr)   corr_cnt_d   = sat_inc(corr_cnt);
    if (xfer && err_uncorr) uncorr_cnt_d = sat_inc(uncorr_cnt);
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      corr_cnt   <= corr_cnt_d;
      uncorr_cnt <= uncorr_cnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Bench for hamming_secded_dec: directed vector table, backpressure/latency/reset
// sequences, saturation on a narrow-counter instance, and randomized traffic.
module tb_hamming_secded_dec;

  typedef struct {
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
    logic [2:0] pos;
  } res_t;

  typedef struct {
    logic [7:0] code;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [7:0] code_in;
  logic [3:0] data_out;
  logic       err_corr, err_uncorr;
  logic [2:0] err_pos;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, cnt_clr2;
  logic [7:0] code_in2;
  logic [3:0] data_out2;
  logic       err_corr2, err_uncorr2;
  logic [2:0] err_pos2;
  logic [1:0] corr_cnt2, uncorr_cnt2;

  hamming_secded_dec #(.DATA_W(4), .PAR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .err_pos(err_pos),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_dec #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .code_in(code_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .data_out(data_out2),
    .err_corr(err_corr2), .err_uncorr(err_uncorr2), .err_pos(err_pos2),
    .cnt_clr(cnt_clr2), .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  int   checks = 0;
  int   failures = 0;
  int   m_corr = 0;
  int   m_unc = 0;
  logic mon_en = 1'b0;
  logic done = 1'b0;
  res_t exp_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference encoder: data at positions 3,5,6,7; parity k at 2^k; bit 0 overall.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    logic       b;
    int         dp[4];
    dp = '{3, 5, 6, 7};
    c = '0;
    for (int j = 0; j < 4; j++) c[dp[j]] = d[j];
    for (int k = 0; k < 3; k++) begin
      b = 1'b0;
      for (int i = 1; i < 8; i++)
        if (((i >> k) & 1) == 1 && i != (1 << k)) b = b ^ c[i];
      c[1 << k] = b;
    end
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic res_t ref_decode(input logic [7:0] c);
    int         s;
    logic       p;
    logic [7:0] f;
    res_t       r;
    s = 0;
    for (int i = 1; i < 8; i++) if (c[i]) s = s ^ i;
    p = ^c;
    f = c;
    r.corr = 1'b0;
    r.uncorr = 1'b0;
    r.pos = 3'(s);
    if (p && s != 0) f[s] = ~f[s];
    if (p) r.corr = 1'b1;
    else if (s != 0) r.uncorr = 1'b1;
    r.data = {f[7], f[6], f[5], f[3]};
    return r;
  endfunction

  // Called on a falling edge; returns on a falling edge with in_valid low.
  task automatic send(input logic [7:0] c, input res_t e);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    code_in = c;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    res_t r;
    #2;
    if (mon_en && !rst) begin
      chk("corr_cnt", corr_cnt, m_corr);
      chk("uncorr_cnt", uncorr_cnt, m_unc);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h expected=no_output", data_out);
        end else begin
          r = exp_q[0];
          chk("data_out", data_out, r.data);
          chk("err_corr", err_corr, r.corr);
          chk("err_uncorr", err_uncorr, r.uncorr);
          chk("err_pos", err_pos, r.pos);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (r.corr && m_corr < 65535) m_corr++;
            if (r.uncorr && m_unc < 65535) m_unc++;
          end
        end
      end
      if (cnt_clr) begin
        m_corr = 0;
        m_unc = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int mode, a, b;

    rst = 1'b1;
    in_valid = 1'b0; code_in = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_valid2 = 1'b0; code_in2 = '0; out_ready2 = 1'b1; cnt_clr2 = 1'b0;

    vecs[0] = '{8'hAA, '{4'hB, 1'b0, 1'b0, 3'd0}};
    vecs[1] = '{8'h8A, '{4'hB, 1'b1, 1'b0, 3'd5}};
    vecs[2] = '{8'hAB, '{4'hB, 1'b1, 1'b0, 3'd0}};
    vecs[3] = '{8'hAC, '{4'hB, 1'b0, 1'b1, 3'd3}};
    vecs[4] = '{8'hFF, '{4'hF, 1'b0, 1'b0, 3'd0}};
    vecs[5] = '{8'hA2, '{4'hB, 1'b1, 1'b0, 3'd3}};
    vecs[6] = '{8'hEF, '{4'hF, 1'b1, 1'b0, 3'd4}};
    vecs[7] = '{8'h7E, '{4'h7, 1'b0, 1'b1, 3'd7}};
    vecs[8] = '{8'h00, '{4'h0, 1'b0, 1'b0, 3'd0}};

    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err_corr", err_corr, 0);
    chk("rst_err_uncorr", err_uncorr, 0);
    chk("rst_err_pos", err_pos, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) send(vecs[i].code, vecs[i].exp);
    drain();
    repeat (2) @(negedge clk);
    chk("tbl_corr_cnt", corr_cnt, 4);
    chk("tbl_uncorr_cnt", uncorr_cnt, 2);

    // Latency: accepted word appears on the second rising edge after the accept
    send(8'hAA, '{4'hB, 1'b0, 1'b0, 3'd0});
    #1;
    chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_cycle2_valid", out_valid, 1);
    chk("lat_cycle2_data", data_out, 4'hB);
    @(negedge clk);
    drain();

    // Backpressure: out_ready low for three cycles while streaming four words
    out_ready = 1'b0;
    in_valid = 1'b1;
    code_in = encode(4'h1);
    #1;
    chk("bp_acc0", in_ready, 1);
    exp_q.push_back(ref_decode(code_in));
    @(negedge clk);
    code_in = encode(4'h2);
    #1;
    chk("bp_acc1", in_ready, 1);
    exp_q.push_back(ref_decode(code_in));
    @(negedge clk);
    code_in = encode(4'h3);
    #1;
    chk("bp_full", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    @(negedge clk);
    #1;
    chk("bp_full2", in_ready, 0);
    chk("bp_hold_data", data_out, 4'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_resume", in_ready, 1);
    exp_q.push_back(ref_decode(code_in));
    @(negedge clk);
    code_in = encode(4'h4);
    #1;
    chk("bp_acc3", in_ready, 1);
    exp_q.push_back(ref_decode(code_in));
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Narrow counters: saturation, then clear colliding with an error beat
    in_valid2 = 1'b1;
    code_in2 = 8'h8A;
    repeat (5) @(negedge clk);
    in_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("sat_corr_cnt", corr_cnt2, 3);
    chk("sat_uncorr_cnt", uncorr_cnt2, 0);
    @(negedge clk);
    in_valid2 = 1'b1;
    code_in2 = 8'h8A;
    @(negedge clk);
    in_valid2 = 1'b0;
    @(negedge clk);
    cnt_clr2 = 1'b1;
    #1;
    chk("clr_beat_valid", out_valid2, 1);
    chk("clr_beat_corr", err_corr2, 1);
    chk("clr_pre_cnt", corr_cnt2, 3);
    @(negedge clk);
    cnt_clr2 = 1'b0;
    #1;
    chk("clr_corr_cnt", corr_cnt2, 0);
    @(negedge clk);

    // Randomized traffic with random backpressure and occasional clears
    fork
      begin
        for (int w = 0; w < 300; w++) begin
          c = encode(4'($urandom));
          mode = $urandom_range(0, 3);
          if (mode == 1) begin
            c = c ^ (8'd1 << $urandom_range(0, 7));
          end else if (mode == 2) begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            c = c ^ (8'd1 << a) ^ (8'd1 << b);
          end else if (mode == 3) begin
            c = 8'($urandom);
          end
          send(c, ref_decode(c));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 9) < 7);
          cnt_clr = ($urandom_range(0, 40) == 0);
        end
        out_ready = 1'b1;
        cnt_clr = 1'b0;
      end
    join
    @(negedge clk);
    drain();

    // Asynchronous reset with words in flight
    send(8'h8A, ref_decode(8'h8A));
    send(8'hAC, ref_decode(8'hAC));
    mon_en = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_corr_cnt", corr_cnt, 0);
    chk("mid_rst_uncorr_cnt", uncorr_cnt, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_err_pos", err_pos, 0);
    chk("mid_rst_err_corr", err_corr, 0);
    exp_q.delete();
    m_corr = 0;
    m_unc = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_output", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
